// File: rtl/accelerator_config_pkg.sv
// accelerator_config_pkg: shared accelerator sizing, buffer state type and tile helpers
package accelerator_config_pkg;

    localparam int TILE_WIDTH = 256;
    localparam int DATA_WIDTH = 8;
    localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_READY
    } wtb_state_e;

    // Number of tile words needed to cover one matrix row of `cols` elements.
    function automatic logic [9:0] ceil_div_tile(input logic [9:0] cols, input int elems = TILE_ELEMS);
        int unsigned sum;
        sum = 32'(cols) + 32'(elems) - 32'd1;
        return 10'(sum / 32'(elems));
    endfunction

endpackage

// File: rtl/weight_tile_buffer_if.sv
// weight_tile_buffer_if: loader-side fill bus and compute-side read bus of the weight tile buffer
interface weight_tile_buffer_if
    import accelerator_config_pkg::*;
#(
    parameter int TILE_WIDTH = accelerator_config_pkg::TILE_WIDTH,
    parameter int DEPTH      = 1024
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  start;
    logic [9:0]            rows;
    logic [9:0]            cols;
    logic [TILE_WIDTH-1:0] tile_in;
    logic                  tile_valid;
    logic                  load_done;
    logic                  rd_en;
    logic [9:0]            rd_row;
    logic [9:0]            rd_tile;
    logic [TILE_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  ready;
    logic [ADDR_W:0]       tile_count;
    logic                  overflow;
    logic                  short_load;

    modport master (
        output start, rows, cols, tile_in, tile_valid, load_done, rd_en, rd_row, rd_tile,
        input  rd_data, rd_valid, ready, tile_count, overflow, short_load
    );

    modport slave (
        input  start, rows, cols, tile_in, tile_valid, load_done, rd_en, rd_row, rd_tile,
        output rd_data, rd_valid, ready, tile_count, overflow, short_load
    );

endinterface

// File: rtl/weight_tile_buffer_tile_ram.sv
// tile_ram: simple dual-port tile storage with registered read, no reset so it maps to block RAM
module tile_ram #(
    parameter int WIDTH  = 256,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port and registered read port; read data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_tile_buffer.sv
// weight_tile_buffer: captures loader tiles row-major into tile RAM and serves (row, tile) reads
module weight_tile_buffer
    import accelerator_config_pkg::*;
#(
    parameter int TILE_WIDTH = accelerator_config_pkg::TILE_WIDTH,
    parameter int DATA_WIDTH = accelerator_config_pkg::DATA_WIDTH,
    parameter int DEPTH      = 1024
) (
    input  logic               clk,
    input  logic               rst,
    weight_tile_buffer_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CW     = ADDR_W + 1;
    localparam int ELEMS  = TILE_WIDTH / DATA_WIDTH;

    wtb_state_e            r_state;
    wtb_state_e            w_next;
    logic [9:0]            r_rows;
    logic [9:0]            r_tpr;
    logic [19:0]           r_expected;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_short;
    logic                  r_rd_valid;
    logic                  r_rd_zero;
    logic [9:0]            w_tpr_in;
    logic [19:0]           w_rd_addr;
    logic [19:0]           w_final;
    logic                  w_rd_oor;
    logic                  w_tile_ok;
    logic                  w_we;
    logic                  w_drop;
    logic                  w_done;
    logic                  w_rd_acc;
    logic [TILE_WIDTH-1:0] w_ram_q;

    assign w_tpr_in  = ceil_div_tile(bus.cols, ELEMS);
    assign w_rd_addr = 20'(bus.rd_row) * 20'(r_tpr) + 20'(bus.rd_tile);
    assign w_rd_oor  = bus.rd_row >= r_rows || bus.rd_tile >= r_tpr || w_rd_addr >= 20'(r_count);
    assign w_tile_ok = 20'(r_count) < r_expected && r_count != CW'(DEPTH);
    assign w_final   = 20'(r_count) + 20'(w_we);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state and per-cycle actions; start overrides everything, including a same-cycle tile.
    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_drop   = 1'b0;
        w_done   = 1'b0;
        w_rd_acc = 1'b0;
        if (bus.start) begin
            w_next = ST_FILL;
        end else if (r_state == ST_FILL) begin
            w_we   = bus.tile_valid && w_tile_ok;
            w_drop = bus.tile_valid && !w_tile_ok;
            w_done = bus.load_done;
            w_next = bus.load_done ? ST_READY : ST_FILL;
        end else if (r_state == ST_READY) begin
            w_drop   = bus.tile_valid;
            w_rd_acc = bus.rd_en;
        end
    end

    // Load geometry, fill counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows     <= '0;
            r_tpr      <= '0;
            r_expected <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_short    <= 1'b0;
        end else if (bus.start) begin
            r_rows     <= bus.rows;
            r_tpr      <= w_tpr_in;
            r_expected <= 20'(bus.rows) * 20'(w_tpr_in);
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            if (w_we) r_count <= r_count + CW'(1);
            if (w_drop) r_overflow <= 1'b1;
            if (w_done && w_final != r_expected) r_short <= 1'b1;
        end
    end

    // Read response tracking; out-of-range requests still answer, with zeroed data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_zero <= w_rd_oor;
        end
    end

    tile_ram #(
        .WIDTH (TILE_WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_tile_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_count[ADDR_W-1:0]),
        .i_wdata(bus.tile_in),
        .i_re   (w_rd_acc && !w_rd_oor),
        .i_raddr(w_rd_addr[ADDR_W-1:0]),
        .o_rdata(w_ram_q)
    );

    assign bus.rd_data    = r_rd_zero ? '0 : w_ram_q;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.ready      = r_state == ST_READY;
    assign bus.tile_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.short_load = r_short;

endmodule
